phy_rx_deser_n: RTL and testbench
=================================

# phy_rx_deser_n

Parametrised N-lane serial receiver for the PHY receive path: deserialises one bit-serial lane per channel at the fast bit clock, aligns each lane independently to a configurable comma word, and delivers W-bit parallel words with a per-lane valid.
It supersedes the fixed two-lane, 8-bit receiver with generic lane count, word width, comma value and lock threshold.
It also adds a per-lane lock indicator.
It sits between the serial link inputs and the downstream word/FIFO logic.

## Interface
- N_LANES, default 2: number of independent serial lanes.
- W, default 8: word width in bits (W >= 2).
- COMMA, default 8'hBC (W bits): alignment/idle word.
- LOCK_CNT, default 4: consecutive aligned commas required to lock (>= 1).
- clk_8f  in  1  bit clock; one serial bit per lane per rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- enable  in  1  global receive enable; low forces all lanes back to search.
- in  in  N_LANES  serial data, bit i = lane i, MSB of each word first.
- data_out  out  N_LANES*W  lane i word at [i*W +: W].
- valid_out  out  N_LANES  lane i word on data_out is data, not comma.
- active_out  out  N_LANES  lane i is in LOCKED.

## Operation
- Per lane registers:
  - shift register sr (W bits), updated every cycle as sr <= {sr[W-2:0], in[i]}, regardless of state or enable.
  - bit_cnt, $clog2(W) bits, counts mod W.
  - comma_cnt, wide enough for LOCK_CNT.
  - state.
- States: SEARCH, ALIGN, LOCKED.
- SEARCH: compare sr to COMMA every cycle.
  - On match: bit_cnt <= 1 and comma_cnt <= 1.
  - Go to ALIGN, or directly to LOCKED if LOCK_CNT == 1.
- ALIGN/LOCKED: bit_cnt increments mod W every cycle. A word boundary is a cycle with bit_cnt == 0; at a boundary sr holds one aligned word.
- ALIGN at boundary:
  - sr == COMMA: comma_cnt++. When the incremented count equals LOCK_CNT, go to LOCKED.
  - sr != COMMA: go to SEARCH, comma_cnt <= 0.
- LOCKED at boundary:
  - sr == COMMA: valid_out[i] <= 0; data_out unchanged.
  - sr != COMMA: data_out lane <= sr, valid_out[i] <= 1.
- data_out, valid_out and active_out are registered. They change only at boundaries or on a state exit, and hold for W cycles between boundaries.
- Leaving LOCKED (enable low): valid_out[i] <= 0, active_out[i] <= 0; data_out holds its last value.
- enable low: every lane goes to SEARCH with bit_cnt = 0 and comma_cnt = 0. This takes priority over every other transition in the same cycle. sr keeps shifting.
- Lanes are fully independent; skew between lanes is allowed and each lane locks on its own phase.
- Lock is never lost on data content; only enable low or reset returns a lane to SEARCH.

## Timing
- Reset (asynchronous, reset_L low): sr = 0, bit_cnt = 0, comma_cnt = 0, state = SEARCH, data_out = 0, valid_out = 0, active_out = 0. Release takes effect on the next edge.
- Comma detection: the first comma is detected on the edge after its last bit is captured. With LOCK_CNT = L and back-to-back commas, the lane reaches LOCKED (L-1)*W cycles after first detection. active_out rises on the edge completing the L-th comma evaluation.
- Data latency: data_out/valid_out update on the edge after the edge that captured the word's last bit, i.e. W+1 edges after the first bit is sampled.
- A non-comma word arriving during ALIGN aborts the lock. Search resumes the next cycle, using the bits already in sr.
- Mid-operation reset: all outputs are 0 immediately (asynchronous) and the lane must re-lock from SEARCH.
- enable deasserted mid-word: the partial word is discarded and no valid pulse is produced.

## Test plan
- Reset checks, with N_LANES=2, W=8, COMMA=BC, LOCK_CNT=4:
  - Reset asserted: all outputs are 0.
  - Reset then idle zeros: all outputs stay 0.
- Lock and data: both lanes send BC x4 then 0x55, 0xA3, then BC.
  - active_out = 2'b11 after the 4th BC.
  - data_out lane = 55 (valid = 1, held 8 cycles), then A3, then valid = 0 on BC.
- Lane skew: lane 1 delayed 3 bits relative to lane 0, same stream as above.
  - Both lanes lock and emit 55, A3.
  - Lane 1 outputs lag lane 0 by exactly 3 cycles.
- Abort in ALIGN: BC, BC, 0x12, then BC x4, 0x77.
  - No active_out after 0x12.
  - Lock after the subsequent 4 BCs; 77 is emitted with valid = 1.
- Enable drop in LOCKED: enable low for 1 cycle mid-word.
  - valid_out and active_out fall on the next edge.
  - No data is emitted until 4 new BCs are received.
- Unaligned start: stream prefixed with 5 random bits before the commas.
  - Alignment is found at the correct bit phase.
  - Output words match the sent words exactly.

Source files
------------

// File: rtl/phy_rx_deser_n.sv
// N-lane serial receiver: per-lane comma search, word alignment and W-bit word output with lock indicator.
// Word appears W+1 clk_8f edges after its first bit; no backpressure, each output word is held for W cycles.
module phy_rx_deser_n #(
  parameter int           N_LANES  = 2,
  parameter int           W        = 8,
  parameter logic [W-1:0] COMMA    = 8'hBC,
  parameter int           LOCK_CNT = 4
) (
  input  logic                 clk_8f,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic [N_LANES-1:0]   in,
  output logic [N_LANES*W-1:0] data_out,
  output logic [N_LANES-1:0]   valid_out,
  output logic [N_LANES-1:0]   active_out
);

  localparam int BCW = (W > 1) ? $clog2(W) : 1;
  localparam int CCW = $clog2(LOCK_CNT + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(W - 1);
  localparam logic [CCW-1:0] LOCK_VAL = CCW'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_ALIGN,
    S_LOCKED
  } state_t;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    state_t         state_q;
    logic [W-1:0]   sr_q;
    logic [W-1:0]   data_q;
    logic [BCW-1:0] bit_cnt_q;
    logic [BCW-1:0] bit_cnt_d;
    logic [CCW-1:0] comma_cnt_q;
    logic [CCW-1:0] comma_cnt_d;
    logic           valid_q;
    logic           active_q;
    logic           is_comma;
    logic           boundary;

    assign is_comma    = (sr_q == COMMA);
    assign boundary    = (bit_cnt_q == '0);
    assign bit_cnt_d   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    assign comma_cnt_d = comma_cnt_q + 1'b1;

    // The shift register runs unconditionally so search can restart on bits already captured.
    always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
        state_q     <= S_SEARCH;
        sr_q        <= '0;
        data_q      <= '0;
        bit_cnt_q   <= '0;
        comma_cnt_q <= '0;
        valid_q     <= 1'b0;
        active_q    <= 1'b0;
      end else begin
        sr_q <= {sr_q[W-2:0], in[i]};
        if (!enable) begin
          state_q     <= S_SEARCH;
          bit_cnt_q   <= '0;
          comma_cnt_q <= '0;
          valid_q     <= 1'b0;
          active_q    <= 1'b0;
        end else begin
          case (state_q)
            S_SEARCH: begin
              if (is_comma) begin
                bit_cnt_q   <= BCW'(1);
                comma_cnt_q <= CCW'(1);
                if (LOCK_CNT == 1) begin
                  state_q  <= S_LOCKED;
                  active_q <= 1'b1;
                end else begin
                  state_q <= S_ALIGN;
                end
              end
            end
            S_ALIGN: begin
              bit_cnt_q <= bit_cnt_d;
              if (boundary) begin
                if (is_comma) begin
                  comma_cnt_q <= comma_cnt_d;
                  if (comma_cnt_d == LOCK_VAL) begin
                    state_q  <= S_LOCKED;
                    active_q <= 1'b1;
                  end
                end else begin
                  state_q     <= S_SEARCH;
                  comma_cnt_q <= '0;
                end
              end
            end
            S_LOCKED: begin
              bit_cnt_q <= bit_cnt_d;
              if (boundary) begin
                if (is_comma) begin
                  valid_q <= 1'b0;
                end else begin
                  data_q  <= sr_q;
                  valid_q <= 1'b1;
                end
              end
            end
            default: begin
              state_q     <= S_SEARCH;
              bit_cnt_q   <= '0;
              comma_cnt_q <= '0;
              valid_q     <= 1'b0;
              active_q    <= 1'b0;
            end
          endcase
        end
      end
    end

    assign data_out[i*W +: W] = data_q;
    assign valid_out[i]       = valid_q;
    assign active_out[i]      = active_q;
  end

endmodule

// File: tb/tb_phy_rx_deser_n.sv
// Directed bench for phy_rx_deser_n: word-level cycle model checked every cycle plus literal timing pins.
module tb_phy_rx_deser_n;

  localparam int         NL    = 2;
  localparam int         W     = 8;
  localparam int         L     = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic        clk_8f  = 1'b0;
  logic        reset_L = 1'b1;
  logic        enable  = 1'b1;
  logic [1:0]  in_r    = 2'b00;
  logic [15:0] data_out;
  logic [1:0]  valid_out;
  logic [1:0]  active_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit q0[$];
  bit q1[$];

  // Model state: last W bits seen, cycle of first comma detection (-1 while searching), lock and outputs.
  logic [7:0] m_sr   [NL];
  logic [7:0] m_data [NL];
  int         anchor [NL];
  bit         m_lock [NL];
  bit         m_val  [NL];
  int         t = 0;

  phy_rx_deser_n #(
    .N_LANES (NL),
    .W       (W),
    .COMMA   (COMMA),
    .LOCK_CNT(L)
  ) dut (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .enable    (enable),
    .in        (in_r),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active_out(active_out)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic [1:0] v, input logic [1:0] a);
    chk({tag, " data"},   data_out,         d);
    chk({tag, " valid"},  16'(valid_out),   16'(v));
    chk({tag, " active"}, 16'(active_out),  16'(a));
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after each edge.
  always @(posedge clk_8f) begin
    logic [15:0] exp_d;
    logic [1:0]  exp_v;
    logic [1:0]  exp_a;
    #1;
    for (int i = 0; i < NL; i++) begin
      if (!reset_L) begin
        m_sr[i] = '0; m_data[i] = '0; anchor[i] = -1; m_lock[i] = 0; m_val[i] = 0;
      end else begin
        if (!enable) begin
          anchor[i] = -1; m_lock[i] = 0; m_val[i] = 0;
        end else if (anchor[i] < 0) begin
          if (m_sr[i] == COMMA) begin
            anchor[i] = t;
            if (L == 1) m_lock[i] = 1;
          end
        end else if (((t - anchor[i]) % W) == 0) begin
          if (!m_lock[i]) begin
            if (m_sr[i] != COMMA) anchor[i] = -1;
            else if ((t - anchor[i]) / W + 1 == L) m_lock[i] = 1;
          end else if (m_sr[i] == COMMA) begin
            m_val[i] = 0;
          end else begin
            m_data[i] = m_sr[i];
            m_val[i]  = 1;
          end
        end
        m_sr[i] = {m_sr[i][6:0], in_r[i]};
      end
    end
    t++;
    exp_d = '0; exp_v = '0; exp_a = '0;
    for (int i = 0; i < NL; i++) begin
      exp_d[i*W +: W] = m_data[i];
      exp_v[i]        = m_val[i];
      exp_a[i]        = m_lock[i];
    end
    chk("model data",   data_out,        exp_d);
    chk("model valid",  16'(valid_out),  16'(exp_v));
    chk("model active", 16'(active_out), 16'(exp_a));
  end

  task automatic push(input int lane, input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      if (lane == 0) q0.push_back(b[k]);
      else           q1.push_back(b[k]);
    end
  endtask

  task automatic push_both(input logic [7:0] b);
    push(0, b);
    push(1, b);
  endtask

  task automatic tick();
    in_r[0] = (q0.size() > 0) ? q0.pop_front() : 1'b0;
    in_r[1] = (q1.size() > 0) ? q1.pop_front() : 1'b0;
    @(posedge clk_8f);
    #2;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    enable  = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk_out("reset asserted", 16'h0000, 2'b00, 2'b00);
    repeat (3) tick();
    reset_L = 1'b1;
    cyc     = 0;
  endtask

  task automatic push_frame();
    repeat (4) push_both(COMMA);
    push_both(8'h55);
    push_both(8'hA3);
    push_both(COMMA);
  endtask

  initial begin
    #2;
    // Reset then idle zeros.
    do_reset();
    run_to(20);
    chk_out("idle", 16'h0000, 2'b00, 2'b00);

    // Lock and data, then asynchronous reset while locked.
    do_reset();
    push_frame();
    run_to(32); chk_out("pre lock",   16'h0000, 2'b00, 2'b00);
    run_to(33); chk_out("lock",       16'h0000, 2'b00, 2'b11);
    run_to(40); chk_out("pre 55",     16'h0000, 2'b00, 2'b11);
    run_to(41); chk_out("word 55",    16'h5555, 2'b11, 2'b11);
    run_to(48); chk_out("hold 55",    16'h5555, 2'b11, 2'b11);
    run_to(49); chk_out("word A3",    16'hA3A3, 2'b11, 2'b11);
    run_to(57); chk_out("comma idle", 16'hA3A3, 2'b00, 2'b11);
    reset_L = 1'b0;
    #1;
    chk_out("mid reset", 16'h0000, 2'b00, 2'b00);

    // Lane 1 delayed by 3 bits.
    do_reset();
    repeat (3) q1.push_back(1'b0);
    push_frame();
    run_to(35); chk_out("skew lock0", 16'h0000, 2'b00, 2'b01);
    run_to(36); chk_out("skew lock1", 16'h0000, 2'b00, 2'b11);
    run_to(41); chk_out("skew 55 l0", 16'h0055, 2'b01, 2'b11);
    run_to(44); chk_out("skew 55 l1", 16'h5555, 2'b11, 2'b11);
    run_to(49); chk_out("skew A3 l0", 16'h55A3, 2'b11, 2'b11);
    run_to(52); chk_out("skew A3 l1", 16'hA3A3, 2'b11, 2'b11);

    // Non-comma during alignment aborts the lock attempt.
    do_reset();
    push_both(COMMA); push_both(COMMA); push_both(8'h12);
    repeat (4) push_both(COMMA);
    push_both(8'h77);
    run_to(25); chk_out("abort",       16'h0000, 2'b00, 2'b00);
    run_to(56); chk_out("relock wait", 16'h0000, 2'b00, 2'b00);
    run_to(57); chk_out("relock",      16'h0000, 2'b00, 2'b11);
    run_to(65); chk_out("word 77",     16'h7777, 2'b11, 2'b11);

    // One-cycle enable drop in the middle of a data word.
    do_reset();
    repeat (4) push_both(COMMA);
    push_both(8'h55); push_both(8'hA3);
    repeat (4) push_both(COMMA);
    push_both(8'h66);
    run_to(44); chk_out("en before", 16'h5555, 2'b11, 2'b11);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    chk_out("en drop",    16'h5555, 2'b00, 2'b00);
    run_to(80); chk_out("en 3 commas", 16'h5555, 2'b00, 2'b00);
    run_to(81); chk_out("en relock",   16'h5555, 2'b00, 2'b11);
    run_to(88); chk_out("en pre 66",   16'h5555, 2'b00, 2'b11);
    run_to(89); chk_out("en word 66",  16'h6666, 2'b11, 2'b11);

    // Five stray bits before the commas shift the alignment phase.
    do_reset();
    foreach (q0[k]) q0.delete(k);
    q0.push_back(1); q0.push_back(0); q0.push_back(1); q0.push_back(1); q0.push_back(0);
    q1.push_back(1); q1.push_back(0); q1.push_back(1); q1.push_back(1); q1.push_back(0);
    push_frame();
    run_to(37); chk_out("unal pre lock", 16'h0000, 2'b00, 2'b00);
    run_to(38); chk_out("unal lock",     16'h0000, 2'b00, 2'b11);
    run_to(46); chk_out("unal 55",       16'h5555, 2'b11, 2'b11);
    run_to(54); chk_out("unal A3",       16'hA3A3, 2'b11, 2'b11);
    run_to(62); chk_out("unal comma",    16'hA3A3, 2'b00, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
